// File: rtl/dcc_pkg.sv
// Shared constants, state encoding and frame assembly for the DCC frame scheduler.
package dcc_pkg;

   localparam int unsigned FRAME_LEN    = 42;
   localparam int unsigned PREAMBLE_LEN = 14;
   localparam int unsigned BCNT_W       = 6;
   localparam logic [7:0]  IDLE_ADDR    = 8'hFF;
   localparam logic [7:0]  IDLE_CMD     = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_SEND = 2'd2
   } dcc_state_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] cmd;
   } dcc_slot_t;

   // Preamble, start bits, address, command, checksum and stop bit, MSB first
   function automatic logic [FRAME_LEN-1:0] dcc_frame(input dcc_slot_t s);
      return {{PREAMBLE_LEN{1'b1}}, 1'b0, s.addr, 1'b0, s.cmd, 1'b0, s.addr ^ s.cmd, 1'b1};
   endfunction

endpackage

// File: rtl/dcc_frame_shifter.sv
// Loads one assembled DCC frame and serialises it MSB first, one bit per handshake.
module dcc_frame_shifter
   import dcc_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_load,
   input  dcc_slot_t i_slot,
   input  logic      i_shift,
   output logic      o_bit,
   output logic      o_last_c
);

   logic [FRAME_LEN-1:0] r_shift;
   logic [BCNT_W-1:0]    r_bcnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift <= '0;
         r_bcnt  <= '0;
      end else if (i_load) begin
         r_shift <= dcc_frame(i_slot);
         r_bcnt  <= '0;
      end else if (i_shift) begin
         r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
         r_bcnt  <= r_bcnt + BCNT_W'(1);
      end
   end

   assign o_bit    = r_shift[FRAME_LEN-1];
   assign o_last_c = (r_bcnt == BCNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/dcc_frame_scheduler.sv
// Round-robin scheduler of repeating DCC command slots with idle-packet fill.
module dcc_frame_scheduler
   import dcc_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned REPEAT    = 3
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic                         enable,
   input  logic                         slot_wr_en,
   input  logic [$clog2(NUM_SLOTS)-1:0] slot_wr_idx,
   input  logic [15:0]                  slot_wr_data,
   input  logic [NUM_SLOTS-1:0]         slot_clr,
   output logic                         bit_valid,
   output logic                         bit_data,
   input  logic                         bit_ready,
   output logic [NUM_SLOTS-1:0]         slot_pending,
   output logic [$clog2(NUM_SLOTS)-1:0] cur_slot,
   output logic                         idle_frame,
   output logic                         frame_done
);

   localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
   localparam int unsigned CNT_W = 4;

   dcc_state_t           r_state, w_state_nxt;
   logic [1:0]           r_sync;
   dcc_slot_t            r_slot [NUM_SLOTS];
   logic [CNT_W-1:0]     r_cnt  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_pending;
   logic [IDX_W-1:0]     r_rr_ptr, r_cur_slot;
   logic                 r_idle, r_done, r_bit_valid, r_rewr;
   logic [IDX_W-1:0]     w_grant, w_idx;
   logic                 w_any, w_hs, w_last, w_end, w_load;
   dcc_slot_t            w_load_slot;
   logic [NUM_SLOTS-1:0] w_dec;

   assign w_hs   = r_bit_valid & bit_ready;
   assign w_end  = w_hs & w_last;
   assign w_load = (r_state == ST_ARB);

   // Round-robin search starting after the last granted slot
   always_comb begin
      w_any   = 1'b0;
      w_grant = r_rr_ptr;
      w_idx   = '0;
      for (int i = 1; i <= int'(NUM_SLOTS); i++) begin
         w_idx = r_rr_ptr + IDX_W'(i);
         if (!w_any && r_pending[w_idx]) begin
            w_any   = 1'b1;
            w_grant = w_idx;
         end
      end
      w_load_slot = '{addr: IDLE_ADDR, cmd: IDLE_CMD};
      if (w_any) w_load_slot = r_slot[w_grant];
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (enable && r_sync[1]) w_state_nxt = ST_ARB;
         ST_ARB:  w_state_nxt = ST_SEND;
         ST_SEND: if (w_end) w_state_nxt = enable ? ST_ARB : ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Reset release is re-timed so the scheduler never leaves IDLE on a raw edge
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_sync      <= '0;
         r_bit_valid <= 1'b0;
         r_done      <= 1'b0;
         r_idle      <= 1'b0;
         r_cur_slot  <= '0;
         r_rr_ptr    <= IDX_W'(NUM_SLOTS - 1);
         r_rewr      <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], 1'b1};
         r_bit_valid <= (w_state_nxt == ST_SEND);
         r_done      <= w_end;
         if (r_state == ST_ARB) begin
            r_idle <= !w_any;
            r_rewr <= w_any && slot_wr_en && (slot_wr_idx == w_grant);
            if (w_any) begin
               r_cur_slot <= w_grant;
               r_rr_ptr   <= w_grant;
            end
         end else if (r_state == ST_SEND && slot_wr_en && slot_wr_idx == r_cur_slot) begin
            r_rewr <= 1'b1;
         end
      end
   end

   // A rewrite during the frame keeps its fresh repeat count
   always_comb begin
      w_dec = '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++)
         w_dec[i] = w_end && !r_idle && !r_rewr && (r_cur_slot == IDX_W'(i)) && (r_cnt[i] != '0);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_pending <= '0;
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            r_slot[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_wr_en && slot_wr_idx == IDX_W'(i)) begin
               r_slot[i]    <= dcc_slot_t'(slot_wr_data);
               r_cnt[i]     <= CNT_W'(REPEAT);
               r_pending[i] <= 1'b1;
            end else if (slot_clr[i]) begin
               r_cnt[i]     <= '0;
               r_pending[i] <= 1'b0;
            end else if (w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
               if (r_cnt[i] == CNT_W'(1)) r_pending[i] <= 1'b0;
            end
         end
      end
   end

   dcc_frame_shifter u_shifter (
      .i_clk    (ACLK),
      .i_rst_n  (ARESETN),
      .i_load   (w_load),
      .i_slot   (w_load_slot),
      .i_shift  (w_hs),
      .o_bit    (bit_data),
      .o_last_c (w_last)
   );

   assign bit_valid    = r_bit_valid;
   assign slot_pending = r_pending;
   assign cur_slot     = r_cur_slot;
   assign idle_frame   = r_idle;
   assign frame_done   = r_done;

endmodule

// File: tb/tb_dcc_frame_scheduler.sv
// Scoreboard bench: a frame-level slot model predicts every frame; a monitor rebuilds frames from handshakes.
module tb_dcc_frame_scheduler;

   localparam int NS = 4;
   localparam int RP = 3;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        enable = 1'b0;
   logic        slot_wr_en = 1'b0;
   logic [1:0]  slot_wr_idx = '0;
   logic [15:0] slot_wr_data = '0;
   logic [3:0]  slot_clr = '0;
   logic        bit_ready = 1'b1;
   logic        bit_valid, bit_data, idle_frame, frame_done;
   logic [3:0]  slot_pending;
   logic [1:0]  cur_slot;

   dcc_frame_scheduler #(.NUM_SLOTS(NS), .REPEAT(RP)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
      .slot_wr_en(slot_wr_en), .slot_wr_idx(slot_wr_idx), .slot_wr_data(slot_wr_data),
      .slot_clr(slot_clr), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
      .slot_pending(slot_pending), .cur_slot(cur_slot), .idle_frame(idle_frame),
      .frame_done(frame_done)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      bit         idle;
      int         slot;
      logic [7:0] addr;
      logic [7:0] cmd;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   frames_seen = 0;
   int   mon_n = 0;
   int   stall_pct = 0;

   // Frame-level reference state
   logic [15:0] m_data[NS];
   int          m_cnt[NS];
   int          m_ptr, m_fl_slot;
   bit          m_busy, m_fl_idle, m_skip;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic m_reset();
      for (int i = 0; i < NS; i++) begin
         m_data[i] = '0;
         m_cnt[i]  = 0;
      end
      m_ptr = NS - 1; m_busy = 0; m_fl_idle = 0; m_fl_slot = 0; m_skip = 0;
   endtask

   function automatic logic [3:0] m_pending();
      logic [3:0] p;
      for (int i = 0; i < NS; i++) p[i] = (m_cnt[i] > 0);
      return p;
   endfunction

   task automatic model_arb();
      exp_t e;
      e.idle = 1; e.slot = 0; e.addr = 8'hFF; e.cmd = 8'h00;
      for (int i = 1; i <= NS; i++) begin
         int s;
         s = (m_ptr + i) % NS;
         if (e.idle && m_cnt[s] > 0) begin
            e.idle = 0; e.slot = s; e.addr = m_data[s][15:8]; e.cmd = m_data[s][7:0];
         end
      end
      if (!e.idle) m_ptr = e.slot;
      m_busy = 1; m_fl_idle = e.idle; m_fl_slot = e.slot; m_skip = 0;
      exp_q.push_back(e);
   endtask

   task automatic model_done();
      if (m_busy && !m_fl_idle && !m_skip && m_cnt[m_fl_slot] > 0) m_cnt[m_fl_slot]--;
      m_busy = 0; m_skip = 0;
   endtask

   // Clears apply first so a same-cycle write wins
   task automatic do_slot(input bit we, input int idx, input logic [15:0] d, input logic [3:0] clr);
      slot_wr_en = we; slot_wr_idx = 2'(idx); slot_wr_data = d; slot_clr = clr;
      for (int i = 0; i < NS; i++) if (clr[i]) m_cnt[i] = 0;
      if (we) begin
         m_data[idx] = d;
         m_cnt[idx]  = RP;
         if (m_busy && !m_fl_idle && idx == m_fl_slot) m_skip = 1;
      end
      tick();
      slot_wr_en = 0; slot_clr = '0;
   endtask

   task automatic wait_hs(input int k);
      int g = 0;
      while (mon_n < k && g < 3000) begin tick(); g++; end
      if (g >= 3000) chk("handshake_timeout", 64'(mon_n), 64'(k));
   endtask

   task automatic wait_frame();
      int f0 = frames_seen;
      int g = 0;
      while (frames_seen == f0 && g < 3000) begin tick(); g++; end
      if (g >= 3000) chk("frame_timeout", 64'(frames_seen), 64'(f0 + 1));
   endtask

   task automatic run_frames(input int n, input bit rnd, input bit lat);
      int f_start = frames_seen;
      enable = 1;
      for (int f = 0; f < n; f++) begin
         model_arb();
         if (f == 0 && lat) begin
            tick(); chk("latency_c1_valid", 64'(bit_valid), 64'(0));
            tick(); chk("latency_c2_valid", 64'(bit_valid), 64'(1));
         end
         if (f == n - 1) begin
            wait_hs(20);
            enable = 0;
         end else if (rnd && $urandom_range(1) == 1) begin
            int idx = $urandom_range(NS - 1);
            int kind = $urandom_range(2);
            wait_hs($urandom_range(40, 1));
            if (kind == 0)      do_slot(1, idx, 16'($urandom), 4'b0);
            else if (kind == 1) do_slot(0, idx, 16'h0, 4'(1 << idx));
            else                do_slot(1, idx, 16'($urandom), 4'(1 << idx));
         end
         wait_frame();
         model_done();
         chk("slot_pending", 64'(slot_pending), 64'(m_pending()));
      end
      repeat (5) tick();
      chk("valid_after_stop", 64'(bit_valid), 64'(0));
      chk("done_count", 64'(frames_seen), 64'(f_start + n));
   endtask

   // Ready driver: stalls with probability stall_pct percent
   initial forever begin
      @(posedge ACLK);
      #1;
      bit_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
   end

   // Monitor: sampled mid-cycle, so valid&ready here is the handshake of the next edge
   initial begin
      logic [41:0] bits, expb;
      bit          prev_stall;
      logic        prev_data;
      exp_t        e;
      bits = '0; prev_stall = 0; prev_data = 0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            mon_n = 0; prev_stall = 0;
         end else begin
            if (prev_stall && bit_valid) chk("stall_hold", 64'(bit_data), 64'(prev_data));
            if (frame_done) begin
               frames_seen++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 64'(frames_seen), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  expb = {14'h3FFF, 1'b0, e.addr, 1'b0, e.cmd, 1'b0, e.addr ^ e.cmd, 1'b1};
                  chk("frame_len", 64'(mon_n), 64'(42));
                  chk("frame_bits", 64'(bits), 64'(expb));
                  chk("idle_frame", 64'(idle_frame), 64'(e.idle));
                  if (!e.idle) chk("cur_slot", 64'(cur_slot), 64'(e.slot));
               end
               mon_n = 0;
            end
            if (bit_valid && bit_ready) begin
               bits = {bits[40:0], bit_data};
               mon_n++;
            end
            prev_stall = bit_valid && !bit_ready;
            prev_data  = bit_data;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      repeat (3) tick();
      chk("rst_bit_valid", 64'(bit_valid), 64'(0));
      chk("rst_bit_data", 64'(bit_data), 64'(0));
      chk("rst_pending", 64'(slot_pending), 64'(0));
      chk("rst_cur_slot", 64'(cur_slot), 64'(0));
      chk("rst_idle_frame", 64'(idle_frame), 64'(0));
      chk("rst_frame_done", 64'(frame_done), 64'(0));
      ARESETN = 1;
      repeat (4) tick();
      chk("idle_no_valid", 64'(bit_valid), 64'(0));

      // Slot 0 repeats three times then idle packets
      do_slot(1, 0, 16'h0335, 4'b0);
      run_frames(5, 0, 1);

      // Two slots interleave round-robin
      do_slot(1, 1, 16'h1122, 4'b0);
      do_slot(1, 3, 16'h3344, 4'b0);
      run_frames(7, 0, 0);

      // Rewrite of the slot in flight, with random stalls from here on
      stall_pct = 30;
      do_slot(1, 2, 16'h1234, 4'b0);
      enable = 1;
      model_arb();
      wait_hs(10);
      do_slot(1, 2, 16'h0A0F, 4'b0);
      wait_frame();
      model_done();
      chk("slot_pending", 64'(slot_pending), 64'(m_pending()));
      run_frames(4, 0, 0);

      // Randomised writes and clears, some landing mid-frame
      for (int r = 0; r < 3; r++) begin
         int nw = $urandom_range(3, 1);
         for (int w = 0; w < nw; w++) do_slot(1, $urandom_range(NS - 1), 16'($urandom), 4'b0);
         run_frames(8, 1, 0);
      end

      // Reset mid-frame
      do_slot(1, 1, 16'h5AA5, 4'b0);
      enable = 1;
      model_arb();
      wait_hs(30);
      ARESETN = 0;
      #1;
      chk("mid_rst_valid", 64'(bit_valid), 64'(0));
      chk("mid_rst_pending", 64'(slot_pending), 64'(0));
      exp_q.delete();
      m_reset();
      enable = 0;
      repeat (2) tick();
      ARESETN = 1;
      run_frames(2, 0, 0);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
